// File: rtl/conv_pkg.sv
// Shared constants and types for the conv accelerator's BRAM arbitration logic.
package conv_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int AW_DEF     = 32;
    localparam int DW_DEF     = 32;
    localparam int STRB_W_DEF = DW_DEF / 8;

    // ID field is sized for the largest supported requester count so one entry type fits every instance.
    localparam int N_REQ_MAX  = 8;
    localparam int ID_W       = $clog2(N_REQ_MAX);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rsp_ent_t;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/conv_bram_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && elig_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/conv_bram_arb.sv
// Round-robin arbiter sharing one single-port BRAM among N requesters, with burst
// locking and read-data routing back to the issuer after a fixed latency.
module conv_bram_arb
    import conv_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*AW-1:0]     req_addr,
    input  logic [N_REQ*DW/8-1:0]   req_wstrb,
    input  logic [N_REQ*DW-1:0]     req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DW-1:0]           rsp_data,
    output logic                    M_en,
    output logic [AW-1:0]           M_addr,
    output logic [DW/8-1:0]         M_W_req,
    output logic [DW-1:0]           M_W_data,
    input  logic [DW-1:0]           M_R_data
);

    localparam int IW = $clog2(N_REQ);
    localparam int SW = strb_w(DW);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          lock_q, lock_d;
    rsp_ent_t      pipe_q [RD_LAT];

    logic [N_REQ-1:0] owner_oh, elig, pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any, xfer;
    logic [SW-1:0]    sel_strb;
    rsp_ent_t         push, head;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // While a lock is held only the owner may be granted; everyone else stalls.
    assign owner_oh = N_REQ'(1) << owner_q;
    assign elig     = lock_q ? (req_valid & owner_oh) : req_valid;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign xfer      = rst && pick_any;
    assign req_ready = rst ? pick_gnt : '0;

    assign sel_strb = req_wstrb[pick_idx*SW +: SW];
    assign M_en     = xfer;
    assign M_addr   = req_addr[pick_idx*AW +: AW];
    assign M_W_data = req_wdata[pick_idx*DW +: DW];
    assign M_W_req  = xfer ? sel_strb : '0;

    assign push.vld = xfer && (sel_strb == '0);
    assign push.id  = ID_W'(pick_idx);
    assign head     = pipe_q[RD_LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = rst && head.vld && (head.id == ID_W'(i));
        end
    end

    assign rsp_data = M_R_data;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (req_lock[pick_idx]) begin
                lock_d  = 1'b1;
                owner_d = pick_idx;
            end else begin
                lock_d = 1'b0;
                ptr_d  = next_ptr(pick_idx);
            end
        end else if (lock_q && !req_valid[owner_q]) begin
            lock_d = 1'b0;
            ptr_d  = next_ptr(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            pipe_q[0] <= push;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_bram_arb.sv
// Directed bench for conv_bram_arb: one RD_LAT=1 instance with a BRAM model, plus an
// RD_LAT=3 instance sharing the same inputs for the reset-flush scenario.
module tb_conv_bram_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*SW-1:0] req_wstrb;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  req_ready, rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [SW-1:0] m_w_req;
    logic [DW-1:0] m_w_data, m_r_data;

    logic [N-1:0]  req_ready3, rsp_valid3;
    logic [DW-1:0] rsp_data3;
    logic          m_en3;
    logic [AW-1:0] m_addr3;
    logic [SW-1:0] m_w_req3;
    logic [DW-1:0] m_w_data3;
    logic [DW-1:0] m_r_data3;
    assign m_r_data3 = 32'hCAFE_0000;

    int n_checks = 0;
    int n_errors = 0;

    conv_bram_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_lock(req_lock), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .M_en(m_en), .M_addr(m_addr), .M_W_req(m_w_req), .M_W_data(m_w_data),
        .M_R_data(m_r_data)
    );

    conv_bram_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
        .req_lock(req_lock), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .M_en(m_en3), .M_addr(m_addr3), .M_W_req(m_w_req3), .M_W_data(m_w_data3),
        .M_R_data(m_r_data3)
    );

    // BRAM model: 16 words, initial contents 0x1000_0000 + index, 1-cycle read.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_q;
    assign m_r_data = rd_q;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            rd_q <= '0;
        end else if (m_en) begin
            if (m_w_req == '0) begin
                rd_q <= mem[m_addr[3:0]];
            end
            for (int b = 0; b < SW; b++) begin
                if (m_w_req[b]) mem[m_addr[3:0]][b*8 +: 8] <= m_w_data[b*8 +: 8];
            end
        end
    end

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [SW-1:0] s,
                           input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_wstrb[i*SW +: SW] = s;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_lock  = '0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    logic [3:0]  t1_rdy  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    logic [3:0]  t1_rsp  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] t1_data [6] = '{32'h0, 32'h1000_000A, 32'h1000_000B, 32'h1000_000C,
                                 32'h1000_000D, 32'h1000_000A};
    logic [31:0] t1_addr [5] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
    logic        lock_seq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_lock  = '0;
        req_addr  = '0;
        req_wstrb = '0;
        req_wdata = '0;
        set_req(0, 32'd3, 4'hF, 32'h5555_5555);
        adv();
        adv();

        // Reset: all outputs quiet even with every requester asking.
        settle();
        chk4("rst_ready", req_ready, 4'b0000);
        chk4("rst_m_en", {3'b0, m_en}, 4'b0000);
        chk4("rst_m_w_req", m_w_req, 4'b0000);
        chk4("rst_rsp_valid", rsp_valid, 4'b0000);
        adv();

        // All valid reads, no lock: 0,1,2,3,0 with responses one cycle later.
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'(10 + i), 4'h0, 32'h0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) idle();
            settle();
            chk4($sformatf("rr_ready[%0d]", k), req_ready, t1_rdy[k]);
            chk4($sformatf("rr_rsp_valid[%0d]", k), rsp_valid, t1_rsp[k]);
            if (k < 5) chk32($sformatf("rr_m_addr[%0d]", k), m_addr, t1_addr[k]);
            if (t1_rsp[k] != 4'b0000) chk32($sformatf("rr_rsp_data[%0d]", k), rsp_data, t1_data[k]);
            adv();
        end

        // Requester 2 writes addr 5, requester 0 reads it back next cycle.
        req_valid = 4'b0100;
        set_req(2, 32'd5, 4'hF, 32'hDEAD_BEEF);
        settle();
        chk4("wr_ready", req_ready, 4'b0100);
        chk4("wr_m_w_req", m_w_req, 4'hF);
        chk32("wr_m_w_data", m_w_data, 32'hDEAD_BEEF);
        chk32("wr_m_addr", m_addr, 32'd5);
        adv();
        req_valid = 4'b0001;
        set_req(0, 32'd5, 4'h0, 32'h0);
        settle();
        chk4("raw_ready", req_ready, 4'b0001);
        chk4("wr_no_rsp", rsp_valid, 4'b0000);
        adv();
        idle();
        settle();
        chk4("raw_rsp_valid", rsp_valid, 4'b0001);
        chk32("raw_rsp_data", rsp_data, 32'hDEAD_BEEF);
        adv();

        // Requester 1 four-beat locked burst while 0 and 3 wait.
        req_valid = 4'b1011;
        set_req(1, 32'd1, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            req_lock = lock_seq[k] ? 4'b0010 : 4'b0000;
            settle();
            chk4($sformatf("burst_ready[%0d]", k), req_ready, 4'b0010);
            adv();
        end
        req_valid = 4'b1001;
        req_lock  = '0;
        settle();
        chk4("post_burst_ready3", req_ready, 4'b1000);
        chk4("post_burst_rsp", rsp_valid, 4'b0010);
        chk32("post_burst_rsp_data", rsp_data, 32'h1000_0001);
        adv();
        settle();
        chk4("post_burst_ready0", req_ready, 4'b0001);
        adv();
        idle();

        // Requester 1 locked, then drops valid mid-burst.
        req_valid = 4'b1011;
        req_lock  = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk4($sformatf("drop_lock_ready[%0d]", k), req_ready, 4'b0010);
            adv();
        end
        req_valid = 4'b1001;
        settle();
        chk4("drop_gap_ready", req_ready, 4'b0000);
        chk4("drop_gap_m_en", {3'b0, m_en}, 4'b0000);
        adv();
        req_lock = '0;
        settle();
        chk4("drop_next_ready", req_ready, 4'b1000);
        adv();
        idle();

        // Partial-strobe write over a full word, then read back.
        req_valid = 4'b1000;
        set_req(3, 32'd7, 4'hF, 32'hAAAA_AAAA);
        settle();
        chk4("strb_full_ready", req_ready, 4'b1000);
        adv();
        set_req(3, 32'd7, 4'b0011, 32'h1122_3344);
        settle();
        chk4("strb_part_w_req", m_w_req, 4'b0011);
        chk32("strb_part_w_data", m_w_data, 32'h1122_3344);
        adv();
        set_req(3, 32'd7, 4'h0, 32'h0);
        settle();
        chk4("strb_rd_w_req", m_w_req, 4'b0000);
        adv();
        idle();
        settle();
        chk4("strb_rsp_valid", rsp_valid, 4'b1000);
        chk32("strb_rsp_data", rsp_data, 32'hAAAA_3344);
        adv();

        // RD_LAT=3 instance: three reads, reset right after, no responses ever.
        req_valid = 4'b0001;
        set_req(0, 32'd1, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk4($sformatf("lat3_issue_ready[%0d]", k), req_ready3, 4'b0001);
            adv();
        end
        idle();
        rst = 1'b0;
        settle();
        chk4("lat3_rst_ready", req_ready3, 4'b0000);
        chk4("lat3_rst_rsp", rsp_valid3, 4'b0000);
        chk4("lat3_rst_m_en", {3'b0, m_en3}, 4'b0000);
        adv();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk4($sformatf("lat3_flush_rsp[%0d]", k), rsp_valid3, 4'b0000);
            adv();
        end
        req_valid = 4'b1111;
        settle();
        chk4("lat3_post_rst_ready", req_ready3, 4'b0001);
        chk4("lat1_post_rst_ready", req_ready, 4'b0001);
        adv();
        idle();
        adv();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_bram_arb.md
# conv_bram_arb

Shares one single-port BRAM port (en/addr/R_data/W_req/W_data, 1-word-per-cycle protocol) among N requesters inside the conv accelerator, such as the param loader, bias fetch and the kernel-buffer fill engines. Each cycle it issues at most one access, grants round-robin with an optional per-requester lock for bursts, and routes read data back to the issuing requester after a fixed BRAM latency.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width (byte strobes = DW/8)
- RD_LAT, 1, BRAM read latency in cycles (1..4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  access request per requester
- req_ready  out  N_REQ  grant; a transfer occurs when valid && ready
- req_lock  in  N_REQ  keep grant after this transfer (burst)
- req_addr  in  N_REQ*AW  word address, requester i at [i*AW +: AW]
- req_wstrb  in  N_REQ*DW/8  byte write strobes; all-zero = read
- req_wdata  in  N_REQ*DW  write data
- rsp_valid  out  N_REQ  read data valid for requester i
- rsp_data  out  DW  read data, shared by all requesters
- M_en  out  1  BRAM enable
- M_addr  out  AW  BRAM address
- M_W_req  out  DW/8  BRAM byte write enables
- M_W_data  out  DW  BRAM write data
- M_R_data  in  DW  BRAM read data, valid RD_LAT cycles after M_en

## Operation
- Eligible set: the lock owner alone if a lock is active; otherwise all i with req_valid[i].
- Pick: the first eligible index scanning from ptr upward, mod N_REQ. req_ready is one-hot or zero, combinational from req_valid, ptr and lock state.
- On a transfer by requester g:
  - M_en=1; M_addr, M_W_req, M_W_data are muxed from g in the same cycle.
  - If req_lock[g]=1, g becomes or stays the lock owner and ptr is held.
  - If req_lock[g]=0, the lock clears and ptr becomes (g+1) mod N_REQ.
- If the lock owner deasserts req_valid, the lock releases that cycle and ptr becomes (owner+1) mod N_REQ. No grant is issued in that cycle.
- Reads: push {1, g} into an RD_LAT-deep pipeline. Writes push {0, x}.
- Pipeline head valid: rsp_valid[id]=1 and rsp_data=M_R_data, both combinational from M_R_data. Otherwise rsp_valid=0 and rsp_data=M_R_data (don't care).
- BRAM ordering is issue order. A read issued the cycle after a write to the same address returns the new data.
- No backpressure on responses. Requesters must accept rsp_valid.

## Timing
- Grant latency: 0 cycles (same-cycle req_ready). Throughput: 1 access per cycle.
- Read response: exactly RD_LAT cycles after the transfer edge.
- Reset: when rst=0 at a rising edge, ptr clears to 0, the lock clears and the pipeline flushes.
  - While rst=0: req_ready=0, M_en=0, M_W_req=0, rsp_valid=0.
  - Reads in flight when reset is asserted produce no response, including across reset release.
- First grant: the first cycle with rst=1; ptr=0, so requester 0 has priority.
- All requesters valid with no locks: grants go 0,1,2,3,0,… one per cycle, with ptr wrapping N_REQ-1 -> 0.
- Lock asserted while others are waiting: the others stall until the owner's unlocked transfer or its valid drops. There is no timeout; burst length is bounded by the requester.

## Structure
- Shared package conv_pkg holds:
  - N_REQ, AW and DW defaults
  - the strobe width constant
  - the struct/typedef for the response pipeline entry {vld, id[$clog2(N_REQ)-1:0]}
- Sub-module rr_pick: purely combinational. Inputs are an N_REQ eligibility vector and ptr; outputs are a one-hot grant and an index. Reused by later arbiters.
- The top level holds ptr, the lock owner/flag, the response shift pipeline and the address/data muxes.

## Test plan
- Reset then req_valid=4'b1111, all reads, no lock, RD_LAT=1: grants 0,1,2,3,0 on consecutive cycles. rsp_valid one-hot matches the grant delayed by 1 cycle, and rsp_data equals BRAM contents at each addr.
- Requester 2 writes 0xDEADBEEF to addr 5 with wstrb=4'hF, then requester 0 reads addr 5 the next cycle: rsp_valid[0] returns 0xDEADBEEF. Requester 2 gets no rsp_valid.
- Requester 1 has 4-beat lock (req_lock=1,1,1,0) while 0 and 3 are valid: beats 1,1,1,1 are granted back-to-back, then requester 3 (ptr=2), then requester 0.
- Requester 1 is locked, then drops valid mid-burst: no grant in that cycle, lock released, next grant to the lowest valid index ≥2 (wrapping).
- RD_LAT=3, 3 reads issued, rst=0 on the cycle after the last issue: no rsp_valid ever for those reads. After release, ptr=0 and requester 0 wins a contested grant.
- wstrb=4'b0011 write of 0x11223344 over 0xAAAAAAAA: a readback returns 0xAAAA3344.
